rk4_step_ctrl: RTL and testbench
================================

RK4_STEP_CTRL -- requirements
Module: rk4_step_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, word width: signed two's complement fixed point.
REQ-002 SHALL have parameter FRAC, default 16, fraction bits (Q16.16 at default).
REQ-003 SHALL have parameter SW, default 16, width of the step counter.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin an integration run.
REQ-007 y0, t0, h  input  N each  initial y, initial t, and step size, sampled when start is accepted.
REQ-008 n_steps  input  SW  number of RK4 steps, sampled when start is accepted.
REQ-009 f_req  output  1  request to the shared f(t,y) evaluator.
REQ-010 f_t, f_y  output  N each  evaluator operands.
REQ-011 f_ack  input  1  evaluator result valid.
REQ-012 f_val  input  N  evaluator result.
REQ-013 yc_y_in, yc_k1, yc_k2, yc_k3, yc_k4  output  N each  operands to the Y-update datapath.
REQ-014 yc_y_out  input  N  combinational Y-update result.
REQ-015 y_out, t_out  output  N each  current state after the last completed step.
REQ-016 step_valid  output  1  one-cycle pulse when a step completes.
REQ-017 busy  output  1  high from start acceptance until done.
REQ-018 done  output  1  one-cycle pulse when the run ends.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, SCALE, UPDATE, DONE, with a stage counter s in 0..3.
REQ-020 IDLE: start=1 SHALL latch the inputs, set s=0, assert busy, and go to REQ next cycle; if n_steps==0, go to DONE instead.
REQ-021 start SHALL be ignored in every state except IDLE.
REQ-022 REQ/WAIT SHALL drive f_req=1 with f_t/f_y held stable until f_ack=1 is sampled; f_ack SHALL be ignored while f_req=0.
REQ-023 Operand schedule: s0 (t, y); s1 (t+h>>>1, y+k1>>>1); s2 (t+h>>>1, y+k2>>>1); s3 (t+h, y+k3).
REQ-024 ">>>1" SHALL be an arithmetic right shift; all adds SHALL wrap modulo 2^N with no saturation.
REQ-025 On f_ack, the FSM SHALL capture f_val, deassert f_req the next cycle, and go to SCALE.
REQ-026 SCALE SHALL compute k_s = (h*f_val) as a 2N-bit signed product, take bits [N+FRAC-1:FRAC] (truncation toward negative infinity), then s++ and go to REQ, or to UPDATE after s==3.
REQ-027 f_req SHALL be low for at least one cycle between consecutive requests.
REQ-028 UPDATE SHALL drive yc_y_in=y, yc_k1=k1, yc_k2=2*k2, yc_k3=2*k3, yc_k4=k4 (doubling by left shift, wrapping).
REQ-029 UPDATE SHALL register y<=yc_y_out and t<=t+h, pulse step_valid, decrement the remaining count, and go to REQ with s=0 or, when the count reaches 0, to DONE.
REQ-030 yc_* outputs SHALL hold their last values outside UPDATE.
REQ-031 DONE SHALL pulse done for one cycle, clear busy, and return to IDLE; y_out/t_out SHALL hold final values until the next accepted start.
REQ-032 Latency per step SHALL be 4*(2+evaluator wait+1)+1 cycles; with f_ack returned the cycle after f_req, this is 17 cycles.

Reset
REQ-033 reset_n low SHALL immediately force IDLE, and set f_req, busy, done, step_valid=0 and y_out, t_out, all k registers, and yc_* outputs to 0.
REQ-034 Reset mid-run SHALL abandon the run; no done pulse; a late f_ack after reset SHALL be ignored.

Verification
REQ-035 f(t,y)=0 evaluator, y0=0x0001_0000, h=0x0000_1000, n_steps=3 -> three step_valid pulses, y_out=0x0001_0000, t_out=0x0000_3000, one done.
REQ-036 f=1.0 constant, y0=0, h=0x0000_8000, n_steps=1 -> yc_k1=0x8000, yc_k2=yc_k3=0x1_0000, yc_k4=0x8000, y_out=yc_y_out, t_out=0x8000.
REQ-037 n_steps=0 with start -> done two cycles later, no f_req, y_out=y0.
REQ-038 Evaluator with f_ack delayed 5 cycles -> f_t/f_y stable throughout, f_req high exactly until the ack cycle; start pulsed mid-run is ignored.
REQ-039 reset_n dropped during WAIT of s2 -> all outputs 0 in the same cycle; new start runs cleanly from s0.
REQ-040 h=0xFFFF_8000 (-0.5), f=-2.0 -> k1=0x0001_0000 (sign handling of product truncation).

Source files
------------

// File: rtl/rk4_step_ctrl_if.sv
// Bundle of run-control, evaluator and Y-update signals shared by the RK4
// step controller and its environment.
interface rk4_step_ctrl_if #(
  parameter int N  = 32,
  parameter int SW = 16
);
  logic                start;
  logic signed [N-1:0] y0;
  logic signed [N-1:0] t0;
  logic signed [N-1:0] h;
  logic [SW-1:0]       n_steps;

  logic                f_req;
  logic signed [N-1:0] f_t;
  logic signed [N-1:0] f_y;
  logic                f_ack;
  logic signed [N-1:0] f_val;

  logic signed [N-1:0] yc_y_in;
  logic signed [N-1:0] yc_k1;
  logic signed [N-1:0] yc_k2;
  logic signed [N-1:0] yc_k3;
  logic signed [N-1:0] yc_k4;
  logic signed [N-1:0] yc_y_out;

  logic signed [N-1:0] y_out;
  logic signed [N-1:0] t_out;
  logic                step_valid;
  logic                busy;
  logic                done;

  modport master (
    input  start, y0, t0, h, n_steps, f_ack, f_val, yc_y_out,
    output f_req, f_t, f_y, yc_y_in, yc_k1, yc_k2, yc_k3, yc_k4,
           y_out, t_out, step_valid, busy, done
  );

  modport slave (
    output start, y0, t0, h, n_steps, f_ack, f_val, yc_y_out,
    input  f_req, f_t, f_y, yc_y_in, yc_k1, yc_k2, yc_k3, yc_k4,
           y_out, t_out, step_valid, busy, done
  );
endinterface

// File: rtl/rk4_step_ctrl.sv
// Sequences one RK4 integration run: four f(t,y) evaluations per step through a
// shared evaluator, k scaling by h, then a Y-update via an external datapath.
module rk4_step_ctrl #(
  parameter int N    = 32,
  parameter int FRAC = 16,
  parameter int SW   = 16
) (
  input logic             clk,
  input logic             reset_n,
  rk4_step_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SCALE,
    UPDATE,
    DONE
  } state_t;

  localparam int PW = N + FRAC;

  state_t              state_q;
  logic [1:0]          s_q;
  logic [SW-1:0]       rem_q;
  logic signed [N-1:0] y_q, t_q, h_q;
  logic signed [N-1:0] k1_q, k2_q, k3_q, k4_q;
  logic signed [N-1:0] fval_q;
  logic                f_req_q;
  logic signed [N-1:0] f_t_q, f_y_q;
  logic signed [N-1:0] yc_y_in_q, yc_k1_q, yc_k2_q, yc_k3_q, yc_k4_q;
  logic                step_valid_q, busy_q, done_q;

  logic signed [N-1:0]  half_h;
  logic signed [N-1:0]  f_t_d, f_y_d;
  logic signed [PW-1:0] h_ext, f_ext, prod;
  logic signed [N-1:0]  k_new;

  always_comb begin
    half_h = h_q >>> 1;
    case (s_q)
      2'd1: begin
        f_t_d = t_q + half_h;
        f_y_d = y_q + (k1_q >>> 1);
      end
      2'd2: begin
        f_t_d = t_q + half_h;
        f_y_d = y_q + (k2_q >>> 1);
      end
      2'd3: begin
        f_t_d = t_q + h_q;
        f_y_d = y_q + k3_q;
      end
      default: begin
        f_t_d = t_q;
        f_y_d = y_q;
      end
    endcase
    // Only bits up to N+FRAC-1 survive, so a product of that width suffices;
    // the arithmetic shift gives truncation toward negative infinity.
    h_ext = {{FRAC{h_q[N-1]}}, h_q};
    f_ext = {{FRAC{fval_q[N-1]}}, fval_q};
    prod  = h_ext * f_ext;
    k_new = N'(prod >>> FRAC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      rem_q        <= '0;
      y_q          <= '0;
      t_q          <= '0;
      h_q          <= '0;
      k1_q         <= '0;
      k2_q         <= '0;
      k3_q         <= '0;
      k4_q         <= '0;
      fval_q       <= '0;
      f_req_q      <= 1'b0;
      f_t_q        <= '0;
      f_y_q        <= '0;
      yc_y_in_q    <= '0;
      yc_k1_q      <= '0;
      yc_k2_q      <= '0;
      yc_k3_q      <= '0;
      yc_k4_q      <= '0;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      step_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            y_q     <= bus.y0;
            t_q     <= bus.t0;
            h_q     <= bus.h;
            rem_q   <= bus.n_steps;
            s_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= (bus.n_steps == '0) ? DONE : REQ;
          end
        end
        REQ: begin
          // Operands are registered together with f_req so they are stable for the whole request.
          f_t_q   <= f_t_d;
          f_y_q   <= f_y_d;
          f_req_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (f_req_q && bus.f_ack) begin
            fval_q  <= bus.f_val;
            f_req_q <= 1'b0;
            state_q <= SCALE;
          end
        end
        SCALE: begin
          case (s_q)
            2'd0: k1_q <= k_new;
            2'd1: k2_q <= k_new;
            2'd2: k3_q <= k_new;
            default: begin
              k4_q      <= k_new;
              yc_y_in_q <= y_q;
              yc_k1_q   <= k1_q;
              yc_k2_q   <= k2_q <<< 1;
              yc_k3_q   <= k3_q <<< 1;
              yc_k4_q   <= k_new;
            end
          endcase
          if (s_q == 2'd3) begin
            s_q     <= '0;
            state_q <= UPDATE;
          end else begin
            s_q     <= s_q + 2'd1;
            state_q <= REQ;
          end
        end
        UPDATE: begin
          y_q          <= bus.yc_y_out;
          t_q          <= t_q + h_q;
          step_valid_q <= 1'b1;
          rem_q        <= rem_q - SW'(1);
          s_q          <= '0;
          state_q      <= (rem_q == SW'(1)) ? DONE : REQ;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.f_req      = f_req_q;
  assign bus.f_t        = f_t_q;
  assign bus.f_y        = f_y_q;
  assign bus.yc_y_in    = yc_y_in_q;
  assign bus.yc_k1      = yc_k1_q;
  assign bus.yc_k2      = yc_k2_q;
  assign bus.yc_k3      = yc_k3_q;
  assign bus.yc_k4      = yc_k4_q;
  assign bus.y_out      = y_q;
  assign bus.t_out      = t_q;
  assign bus.step_valid = step_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_rk4_step_ctrl.sv
// Bench for rk4_step_ctrl: a delayed-ack evaluator, a Y-update datapath and a
// plain-arithmetic RK4 reference drive a table of runs plus a reset corner case.
module tb_rk4_step_ctrl;
  localparam int N    = 32;
  localparam int FRAC = 16;
  localparam int SW   = 16;

  typedef logic signed [N-1:0] word_t;

  typedef struct {
    word_t y0, t0, h;
    int    n;
    int    mode;
    word_t c;
    int    delay;
    bit    mid_start;
    word_t ey, et, ek1, ek2, ek3, ek4;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rk4_step_ctrl_if #(.N(N), .SW(SW)) ifc ();
  rk4_step_ctrl #(.N(N), .FRAC(FRAC), .SW(SW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(ifc)
  );

  int    compared = 0;
  int    mismatched = 0;
  int    cur_mode = 0;
  int    cur_delay = 0;
  word_t cur_c = '0;
  logic  eval_ack = 1'b0;
  logic  stray_ack = 1'b0;
  word_t eval_val = '0;
  vec_t  vecs[$];

  function automatic word_t yupd(word_t a, word_t k1, word_t k2, word_t k3, word_t k4);
    word_t s;
    s = k1 + k2 + k3 + k4;
    return a + s / 32'sd6;
  endfunction

  function automatic word_t fmodel(int mode, word_t c, word_t t, word_t y);
    case (mode)
      0: return '0;
      1: return 32'sh0001_0000;
      2: return 32'shFFFE_0000;
      default: return (y >>> 2) - (t >>> 1) + c;
    endcase
  endfunction

  function automatic word_t scale(word_t h, word_t f);
    longint p;
    p = longint'(h) * longint'(f);
    return word_t'(p >>> FRAC);
  endfunction

  // Classic RK4 with the h/2 midpoints, run for 'steps' steps.
  function automatic void model(input vec_t v, input int steps, output word_t y, output word_t t,
                                output word_t k1, output word_t k2d, output word_t k3d,
                                output word_t k4);
    word_t a, b, c3, d;
    y = v.y0; t = v.t0; k1 = '0; k2d = '0; k3d = '0; k4 = '0;
    for (int i = 0; i < steps; i++) begin
      a   = scale(v.h, fmodel(v.mode, v.c, t, y));
      b   = scale(v.h, fmodel(v.mode, v.c, t + (v.h >>> 1), y + (a >>> 1)));
      c3  = scale(v.h, fmodel(v.mode, v.c, t + (v.h >>> 1), y + (b >>> 1)));
      d   = scale(v.h, fmodel(v.mode, v.c, t + v.h, y + c3));
      k1  = a;
      k2d = b * 2;
      k3d = c3 * 2;
      k4  = d;
      y   = yupd(y, k1, k2d, k3d, k4);
      t   = t + v.h;
    end
  endfunction

  function automatic vec_t mk(word_t y0, word_t t0, word_t h, int n, int mode, word_t c, int delay,
                              bit mid, word_t ey, word_t et, word_t k1, word_t k2, word_t k3,
                              word_t k4);
    vec_t v;
    v.y0 = y0; v.t0 = t0; v.h = h; v.n = n; v.mode = mode; v.c = c; v.delay = delay;
    v.mid_start = mid; v.ey = ey; v.et = et; v.ek1 = k1; v.ek2 = k2; v.ek3 = k3; v.ek4 = k4;
    return v;
  endfunction

  function automatic vec_t rand_vec(int mode);
    vec_t v;
    v = mk(word_t'($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000,
           word_t'($urandom_range(0, 32'h0001_0000)),
           word_t'($urandom_range(0, 32'h0000_3000)) - 32'sh0000_1800,
           $urandom_range(1, 4), mode, word_t'($urandom), $urandom_range(0, 2), 1'b0,
           '0, '0, '0, '0, '0, '0);
    model(v, v.n, v.ey, v.et, v.ek1, v.ek2, v.ek3, v.ek4);
    return v;
  endfunction

  assign ifc.f_ack    = eval_ack | stray_ack;
  assign ifc.f_val    = eval_val;
  assign ifc.yc_y_out = yupd(ifc.yc_y_in, ifc.yc_k1, ifc.yc_k2, ifc.yc_k3, ifc.yc_k4);

  // Evaluator: acks on the second falling edge that sees f_req, plus cur_delay extra cycles.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        eval_ack = 1'b0;
        cnt = 0;
      end else if (eval_ack) begin
        eval_ack = 1'b0;
        cnt = 0;
      end else if (ifc.f_req) begin
        cnt++;
        if (cnt == 2 + cur_delay) begin
          eval_ack = 1'b1;
          eval_val = fmodel(cur_mode, cur_c, ifc.f_t, ifc.f_y);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic start_run(input vec_t v);
    cur_mode = v.mode; cur_c = v.c; cur_delay = v.delay;
    @(negedge clk); #1;
    ifc.y0 = v.y0; ifc.t0 = v.t0; ifc.h = v.h; ifc.n_steps = SW'(v.n);
    ifc.start = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    word_t my, mt, m1, m2, m3, m4, pt, py;
    int    len, cyc, sv, rises, errs, done_cyc;
    logic  pr, pa;
    len = 17 + 4 * v.delay;
    start_run(v);
    cyc = 0; sv = 0; rises = 0; errs = 0; done_cyc = -1;
    pr = 1'b0; pa = 1'b0; pt = '0; py = '0;
    while (done_cyc < 0 && cyc < len * v.n + 40) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 1) ifc.start = 1'b0;
      if (v.mid_start && cyc == 30) begin
        ifc.start = 1'b1; ifc.y0 = ~v.y0; ifc.n_steps = SW'(7);
      end
      if (v.mid_start && cyc == 31) ifc.start = 1'b0;
      if (ifc.f_req && !pr) rises++;
      if (ifc.f_req && pr && (ifc.f_t !== pt || ifc.f_y !== py)) errs++;
      if (pa && ifc.f_req) errs++;
      if (pr && !ifc.f_req && !pa) errs++;
      if (!ifc.busy && !ifc.done) errs++;
      if (ifc.step_valid) begin
        sv++;
        model(v, sv, my, mt, m1, m2, m3, m4);
        check($sformatf("v%0d_step%0d_y", idx, sv), ifc.y_out, my);
        check($sformatf("v%0d_step%0d_t", idx, sv), ifc.t_out, mt);
        check($sformatf("v%0d_step%0d_cycle", idx, sv), cyc, len * sv + 1);
      end
      if (ifc.done) done_cyc = cyc;
      pr = ifc.f_req; pa = ifc.f_ack; pt = ifc.f_t; py = ifc.f_y;
    end
    check($sformatf("v%0d_done_cycle", idx), done_cyc, len * v.n + 2);
    check($sformatf("v%0d_steps", idx), sv, v.n);
    check($sformatf("v%0d_req_count", idx), rises, 4 * v.n);
    check($sformatf("v%0d_handshake_errs", idx), errs, 0);
    check($sformatf("v%0d_y_out", idx), ifc.y_out, v.ey);
    check($sformatf("v%0d_t_out", idx), ifc.t_out, v.et);
    if (v.n > 0) begin
      check($sformatf("v%0d_yc_k1", idx), ifc.yc_k1, v.ek1);
      check($sformatf("v%0d_yc_k2", idx), ifc.yc_k2, v.ek2);
      check($sformatf("v%0d_yc_k3", idx), ifc.yc_k3, v.ek3);
      check($sformatf("v%0d_yc_k4", idx), ifc.yc_k4, v.ek4);
    end
    @(negedge clk); #1;
    check($sformatf("v%0d_after_done", idx), {ifc.done, ifc.busy, ifc.f_req}, '0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {ifc.f_req, ifc.busy, ifc.done, ifc.step_valid}, '0);
    check({name, "_y_out"}, ifc.y_out, '0);
    check({name, "_t_out"}, ifc.t_out, '0);
    check({name, "_yc"}, ifc.yc_y_in | ifc.yc_k1 | ifc.yc_k2 | ifc.yc_k3 | ifc.yc_k4, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   errs;
    ifc.start = 1'b0; ifc.y0 = '0; ifc.t0 = '0; ifc.h = '0; ifc.n_steps = '0;

    vecs.push_back(mk(32'sh0001_0000, 0, 32'sh0000_1000, 3, 0, 0, 0, 1'b0,
                      32'sh0001_0000, 32'sh0000_3000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'sh0000_8000, 1, 1, 0, 0, 1'b0,
                      32'sh0000_8000, 32'sh0000_8000,
                      32'sh0000_8000, 32'sh0001_0000, 32'sh0001_0000, 32'sh0000_8000));
    vecs.push_back(mk(32'sh0001_0000, 0, 32'shFFFF_8000, 1, 2, 0, 0, 1'b0,
                      32'sh0002_0000, 32'shFFFF_8000,
                      32'sh0001_0000, 32'sh0002_0000, 32'sh0002_0000, 32'sh0001_0000));
    vecs.push_back(mk(32'sh1234_5678, 32'sh0000_1111, 32'sh0000_0100, 0, 3, 0, 0, 1'b0,
                      32'sh1234_5678, 32'sh0000_1111, 0, 0, 0, 0));
    vecs.push_back(mk(32'sh0001_0000, 0, 32'sh0000_1000, 2, 1, 0, 5, 1'b1,
                      32'sh0001_2000, 32'sh0000_2000,
                      32'sh0000_1000, 32'sh0000_2000, 32'sh0000_2000, 32'sh0000_1000));
    for (int i = 0; i < 6; i++) vecs.push_back(rand_vec(3));
    vecs.push_back(rand_vec(1));

    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset during the s2 evaluation of the second step (step length 29 with delay 3).
    v = rand_vec(3);
    v.n = 2; v.delay = 3;
    start_run(v);
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk); #1;
      if (c == 1) ifc.start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    check("mid_reset_ft_fy", ifc.f_t | ifc.f_y, '0);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    stray_ack = 1'b1;
    @(negedge clk); #1;
    stray_ack = 1'b0;
    errs = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (ifc.f_req || ifc.busy || ifc.done || ifc.step_valid) errs++;
    end
    check("late_ack_ignored", errs, 0);
    v = rand_vec(3);
    run_vec(v, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
